// File: rtl/img_stream_checker.sv
// rtl/img_stream_checker.sv - raster-stream comparator: per-channel tolerance compare, saturating error counts, first-mismatch latch
module img_stream_checker #(
    parameter int COLS  = 640,
    parameter int ROWS  = 480,
    parameter int PIX_W = 8,
    parameter int CH    = 4,
    parameter int TOL   = 0,
    parameter int CNT_W = 20,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  dut_valid,
    input  logic [CH*PIX_W-1:0]   dut_data,
    output logic                  dut_ready,
    input  logic                  gold_valid,
    input  logic [CH*PIX_W-1:0]   gold_data,
    output logic                  gold_ready,
    output logic [CH*CNT_W-1:0]   err_cnt,
    output logic                  first_err_vld,
    output logic [CH-1:0]         first_err_ch,
    output logic [ROW_W-1:0]      first_err_row,
    output logic [COL_W-1:0]      first_err_col,
    output logic                  busy,
    output logic                  done,
    output logic                  pass
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [PIX_W:0]   TOL_V    = (PIX_W+1)'(TOL);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic             accept, clear, last_beat;
    logic [CH-1:0]    mis_mask;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;

    // Differences are formed in PIX_W+1 bits so the full 0..2^PIX_W-1 range is representable
    for (genvar k = 0; k < CH; k++) begin : g_cmp
        logic [PIX_W:0] a, b, diff;
        assign a           = {1'b0, dut_data[k*PIX_W +: PIX_W]};
        assign b           = {1'b0, gold_data[k*PIX_W +: PIX_W]};
        assign diff        = (a >= b) ? (a - b) : (b - a);
        assign mis_mask[k] = diff > TOL_V;
    end

    assign accept    = (state == S_RUN) && dut_valid && gold_valid;
    assign clear     = start && (state != S_RUN);
    assign last_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last_beat) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == S_RUN);
        done       = (state == S_DONE);
        dut_ready  = (state == S_RUN) && gold_valid;
        gold_ready = (state == S_RUN) && dut_valid;
        pass       = (state == S_DONE) && (err_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_ch  <= '0;
            first_err_row <= '0;
            first_err_col <= '0;
            row_q         <= '0;
            col_q         <= '0;
        end else if (clear) begin
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_ch  <= '0;
            first_err_row <= '0;
            first_err_col <= '0;
            row_q         <= '0;
            col_q         <= '0;
        end else if (accept) begin
            for (int k = 0; k < CH; k++) begin
                if (mis_mask[k] && (err_cnt[k*CNT_W +: CNT_W] != CNT_MAX))
                    err_cnt[k*CNT_W +: CNT_W] <= err_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (!first_err_vld && (mis_mask != '0)) begin
                first_err_vld <= 1'b1;
                first_err_ch  <= mis_mask;
                first_err_row <= row_q;
                first_err_col <= col_q;
            end
            // Row stays at its last value after the final beat; only start rewinds it
            if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q != ROW_LAST) row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_img_stream_checker.sv
// tb/tb_img_stream_checker.sv - randomized bench: three checker variants against a behavioural frame model
module tb_img_stream_checker;

    localparam int COLS = 8, ROWS = 4, PIX_W = 8, CH = 4, NB = COLS * ROWS;
    localparam int NI = 3;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dv = 1'b0, gv = 1'b0;
    logic [CH*PIX_W-1:0] dd = '0, gd = '0;

    logic [NI-1:0]         dr_v, gr_v, fv_v, busy_v, done_v, pass_v;
    logic [NI-1:0][CH-1:0] fch_v;
    logic [NI-1:0][1:0]    frow_v;
    logic [NI-1:0][2:0]    fcol_v;
    logic [CH*20-1:0]      ec0, ec1;
    logic [CH*3-1:0]       ec2;

    int vectors = 0, errors = 0;
    int tol_i [NI] = '{0, 1, 0};
    int sat_i [NI] = '{1048575, 1048575, 7};

    always #5 clk = ~clk;

    img_stream_checker #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .CH(CH), .TOL(0), .CNT_W(20)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_valid(dv), .dut_data(dd), .dut_ready(dr_v[0]),
        .gold_valid(gv), .gold_data(gd), .gold_ready(gr_v[0]), .err_cnt(ec0), .first_err_vld(fv_v[0]),
        .first_err_ch(fch_v[0]), .first_err_row(frow_v[0]), .first_err_col(fcol_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]));
    img_stream_checker #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .CH(CH), .TOL(1), .CNT_W(20)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_valid(dv), .dut_data(dd), .dut_ready(dr_v[1]),
        .gold_valid(gv), .gold_data(gd), .gold_ready(gr_v[1]), .err_cnt(ec1), .first_err_vld(fv_v[1]),
        .first_err_ch(fch_v[1]), .first_err_row(frow_v[1]), .first_err_col(fcol_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]));
    img_stream_checker #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .CH(CH), .TOL(0), .CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_valid(dv), .dut_data(dd), .dut_ready(dr_v[2]),
        .gold_valid(gv), .gold_data(gd), .gold_ready(gr_v[2]), .err_cnt(ec2), .first_err_vld(fv_v[2]),
        .first_err_ch(fch_v[2]), .first_err_row(frow_v[2]), .first_err_col(fcol_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]));

    function automatic int act_cnt(int i, int k);
        if (i == 0) return int'(ec0[k*20 +: 20]);
        if (i == 1) return int'(ec1[k*20 +: 20]);
        return int'(ec2[k*3 +: 3]);
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame = NB accepted beats, position = accept index
    int m_state = 0;  // 0 idle, 1 run, 2 done
    int m_n = 0;
    int m_cnt [NI][CH];
    int m_fv [NI], m_fch [NI], m_frow [NI], m_fcol [NI];

    task automatic m_clear();
        m_n = 0;
        for (int i = 0; i < NI; i++) begin
            m_fv[i] = 0; m_fch[i] = 0; m_frow[i] = 0; m_fcol[i] = 0;
            for (int k = 0; k < CH; k++) m_cnt[i][k] = 0;
        end
    endtask

    initial m_clear();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_clear();
        end else if (start && m_state != 1) begin
            m_state = 1;
            m_clear();
        end else if (m_state == 1 && dv && gv) begin
            for (int i = 0; i < NI; i++) begin
                int mask;
                mask = 0;
                for (int k = 0; k < CH; k++) begin
                    int d;
                    d = int'(dd[k*PIX_W +: PIX_W]) - int'(gd[k*PIX_W +: PIX_W]);
                    if (d < 0) d = -d;
                    if (d > tol_i[i]) begin
                        mask |= (1 << k);
                        if (m_cnt[i][k] < sat_i[i]) m_cnt[i][k]++;
                    end
                end
                if (mask != 0 && m_fv[i] == 0) begin
                    m_fv[i] = 1; m_fch[i] = mask;
                    m_frow[i] = m_n / COLS; m_fcol[i] = m_n % COLS;
                end
            end
            m_n++;
            if (m_n == NB) m_state = 2;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int allz;
            allz = 1;
            for (int k = 0; k < CH; k++) begin
                chk($sformatf("err_cnt[%0d][%0d]", i, k), act_cnt(i, k), m_cnt[i][k]);
                if (m_cnt[i][k] != 0) allz = 0;
            end
            chk($sformatf("busy[%0d]", i), int'(busy_v[i]), int'(m_state == 1));
            chk($sformatf("done[%0d]", i), int'(done_v[i]), int'(m_state == 2));
            chk($sformatf("pass[%0d]", i), int'(pass_v[i]), int'(m_state == 2 && allz == 1));
            chk($sformatf("dut_ready[%0d]", i), int'(dr_v[i]), int'(m_state == 1 && gv));
            chk($sformatf("gold_ready[%0d]", i), int'(gr_v[i]), int'(m_state == 1 && dv));
            chk($sformatf("first_vld[%0d]", i), int'(fv_v[i]), m_fv[i]);
            chk($sformatf("first_ch[%0d]", i), int'(fch_v[i]), m_fch[i]);
            chk($sformatf("first_row[%0d]", i), int'(frow_v[i]), m_frow[i]);
            chk($sformatf("first_col[%0d]", i), int'(fcol_v[i]), m_fcol[i]);
        end
    end

    logic [7:0] g_mem [NB][CH];
    logic [7:0] d_mem [NB][CH];

    task automatic gen(int sc);
        for (int n = 0; n < NB; n++) begin
            for (int k = 0; k < CH; k++) begin
                int g, d;
                g = $urandom_range(0, 255);
                d = g;
                case (sc)
                    1: if (k == 2 && (n == 11 || n == 31)) d = g ^ 8'h5a;
                    2: begin
                        if (k == 0) begin
                            g = $urandom_range(2, 254);
                            d = (n == 20) ? g - 2 : g + 1;
                        end
                        if (k == 3 && n == 5) begin g = 0; d = 255; end
                    end
                    3: if (k == 1 && n < 10) d = g ^ 8'h80;
                    4: if ($urandom_range(0, 5) == 0) d = (g + $urandom_range(0, 4) + 254) % 256;
                    default: ;
                endcase
                g_mem[n][k] = 8'(g);
                d_mem[n][k] = 8'(d);
            end
        end
    endtask

    task automatic drive(int idx, int mode, int cyc);
        case (mode)
            0: begin dv = 1'b1; gv = 1'b1; end
            1: begin dv = 1'b1; gv = cyc[0]; end
            default: begin dv = ($urandom_range(0, 3) != 0); gv = ($urandom_range(0, 3) != 0); end
        endcase
        for (int k = 0; k < CH; k++) begin
            dd[k*PIX_W +: PIX_W] = dv ? d_mem[idx][k] : 8'($urandom);
            gd[k*PIX_W +: PIX_W] = gv ? g_mem[idx][k] : 8'($urandom);
        end
    endtask

    task automatic run_frame(int sc, int mode, int start_at, int rst_at);
        int idx, cyc;
        logic acc;
        gen(sc);
        idx = 0; cyc = 0;
        start = 1'b1;
        drive(0, mode, 1);
        @(posedge clk); #2;
        start = 1'b0;
        while (idx < NB && cyc < 400) begin
            drive(idx, mode, cyc);
            if (cyc == start_at) start = 1'b1;
            if (idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", int'(busy_v), 0);
                chk("rst_err_cnt0", int'(ec0 != '0), 0);
                chk("rst_first_vld", int'(fv_v), 0);
                chk("rst_ready", int'(dr_v | gr_v), 0);
                @(posedge clk); @(posedge clk); #2;
                rst_n = 1'b1;
                return;
            end
            #1;
            acc = dv && dr_v[0];
            @(posedge clk); #2;
            start = 1'b0;
            cyc++;
            if (acc) idx++;
        end
        chk("frame_accepts", idx, NB);
        if (mode == 0) chk("frame_cycles", cyc, NB);
        dv = 1'b0; gv = 1'b0;
        #1;
        chk("frame_done", int'(done_v[0]), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        dv = 1'b1; gv = 1'b1;
        #1;
        chk("reset_ready", int'(dr_v | gr_v), 0);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", int'(dr_v | gr_v), 0);
        chk("idle_busy", int'(busy_v | done_v | pass_v), 0);
        @(posedge clk); #2;

        run_frame(0, 0, -1, -1);
        chk("identical_pass", int'(pass_v[0]), 1);
        chk("identical_cnt", int'(ec0 != '0), 0);

        run_frame(1, 0, -1, -1);
        chk("ch2_cnt", act_cnt(0, 2), 2);
        chk("ch2_others", act_cnt(0, 0) + act_cnt(0, 1) + act_cnt(0, 3), 0);
        chk("ch2_mask", int'(fch_v[0]), 4);
        chk("ch2_row", int'(frow_v[0]), 1);
        chk("ch2_col", int'(fcol_v[0]), 3);
        chk("ch2_pass", int'(pass_v[0]), 0);

        run_frame(2, 2, -1, -1);
        chk("tol1_ch0", act_cnt(1, 0), 1);
        chk("tol1_ch3_diff255", act_cnt(1, 3), 1);
        chk("tol0_ch0", act_cnt(0, 0), 32);
        chk("tol1_first_ch", int'(fch_v[1]), 8);
        chk("tol1_first_col", int'(fcol_v[1]), 5);

        run_frame(3, 1, -1, -1);
        chk("ch1_wide_cnt", act_cnt(0, 1), 10);
        chk("ch1_sat_cnt", act_cnt(2, 1), 7);

        run_frame(4, 2, -1, 15);
        run_frame(4, 2, -1, -1);
        run_frame(4, 2, 8, -1);
        run_frame(0, 0, -1, -1);
        chk("rerun_pass", int'(pass_v[0]), 1);
        repeat (3) run_frame(4, 2, -1, -1);

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
